// File: rtl/axi_burst_slave.sv
// axi_burst_slave: AXI4 memory slave with ID tagging, INCR/FIXED bursts, byte strobes and SLVERR reporting.
module axi_burst_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int SZ = $clog2(STRB);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [7:0]            w_len, w_cnt;
    logic                  w_incr, w_bad, w_err;
    logic                  aw_bad, w_in, w_last, w_err_nx, w_we;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_idx, rd_idx;
    logic [7:0]            r_len, r_cnt;
    logic                  r_incr, r_bad, ar_bad, r_idle, rd_bad;
    logic [DATA_WIDTH-1:0] rd_word;

    assign aw_bad   = awsize != 3'(SZ) || awburst[1];
    assign w_in     = w_idx < ADDR_WIDTH'(MEM_DEPTH);
    assign w_last   = w_cnt == w_len;
    assign w_err_nx = w_err | !w_in | (wlast != w_last);
    assign w_we     = w_state == W_DATA && wvalid && !w_bad && w_in;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_incr  <= 1'b0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_idx   <= awaddr >> SZ;
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_incr  <= awburst == 2'b01;
                        w_bad   <= aw_bad;
                        w_err   <= aw_bad;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_err <= w_err_nx;
                        w_cnt <= w_cnt + 1'b1;
                        if (w_incr) w_idx <= w_idx + 1'b1;
                        // awlen alone ends the burst; wlast only feeds the error flag
                        if (w_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= w_err_nx ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        for (int b = 0; b < STRB; b++)
            if (w_we && wstrb[b]) mem[w_idx[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
    end

    // One lookup path serves both the first beat (from AR) and each following beat
    assign ar_bad  = arsize != 3'(SZ) || arburst[1];
    assign r_idle  = r_state == R_IDLE;
    assign rd_idx  = r_idle ? araddr >> SZ : (r_incr ? r_idx + 1'b1 : r_idx);
    assign rd_bad  = (r_idle ? ar_bad : r_bad) || rd_idx >= ADDR_WIDTH'(MEM_DEPTH);
    assign rd_word = rd_bad ? '0 : mem[rd_idx[IW-1:0]];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_incr  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        r_idx   <= rd_idx;
                        r_len   <= arlen;
                        r_cnt   <= '0;
                        r_incr  <= arburst == 2'b01;
                        r_bad   <= ar_bad;
                        rdata   <= rd_word;
                        rresp   <= rd_bad ? 2'b10 : 2'b00;
                        rlast   <= arlen == 8'd0;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_idx <= rd_idx;
                            r_cnt <= r_cnt + 1'b1;
                            rdata <= rd_word;
                            rresp <= rd_bad ? 2'b10 : 2'b00;
                            rlast <= r_cnt + 8'd1 == r_len;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_slave.sv
// tb_axi_burst_slave: scoreboard bench; a memory model predicts B and R responses queued at stimulus time.
module tb_axi_burst_slave;
    logic        aclk = 1'b0, areset_n = 1'b0;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 aclk = ~aclk;

    axi_burst_slave dut (
        .aclk(aclk), .areset_n(areset_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;

    int          checks = 0, errors = 0;
    logic [31:0] model [256];
    rbeat_t      exp_r[$];
    logic [5:0]  exp_b[$];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input int early);
        logic bad, err, lst;
        logic [5:0] e;
        int n, idx;
        bad = burst[1] || size != 3'd2;
        err = bad;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL aw_wait awready=%b want 1", awready); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL wready_after_aw got %b want 1", wready); end
        for (int b = 0; b <= int'(len); b++) begin
            lst = early >= 0 ? (b == early) : (b == int'(len));
            wdata = wd[b]; wstrb = ws[b]; wlast = lst; wvalid = 1'b1;
            @(posedge aclk); #1;
            idx = int'(addr >> 2) + (burst == 2'b01 ? b : 0);
            if (idx >= 256 || lst != (b == int'(len))) err = 1'b1;
            if (!bad && idx < 256)
                for (int k = 0; k < 4; k++) if (ws[b][k]) model[idx][8*k +: 8] = wd[b][8*k +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_b.push_back({id, err ? 2'b10 : 2'b00});
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_timing got %b want 1", bvalid); end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        e = exp_b.pop_front();
        checks++;
        if ({bid, bresp} !== e) begin
            errors++;
            $display("FAIL b_resp addr=%h bid=%h bresp=%b want bid=%h bresp=%b", addr, bid, bresp, e[5:2], e[1:0]);
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL b_done awready=%b bvalid=%b want 1 0", awready, bvalid);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input bit toggle);
        rbeat_t x;
        int n, idx;
        for (int b = 0; b <= int'(len); b++) begin
            idx = int'(addr >> 2) + (burst == 2'b01 ? b : 0);
            x.id = id;
            x.last = b == int'(len);
            x.data = (burst[1] || idx >= 256) ? 32'h0 : model[idx];
            x.resp = (burst[1] || idx >= 256) ? 2'b10 : 2'b00;
            exp_r.push_back(x);
        end
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_after_ar got %b want 1", rvalid); end
        n = 0;
        while (exp_r.size() > 0 && n < 600) begin
            rready = !toggle || (n % 2 == 1);
            if (rvalid) begin
                checks++;
                if (rdata !== exp_r[0].data || rresp !== exp_r[0].resp || rlast !== exp_r[0].last || rid !== exp_r[0].id) begin
                    errors++;
                    $display("FAIL r_beat addr=%h got data=%h resp=%b last=%b id=%h want data=%h resp=%b last=%b id=%h",
                             addr, rdata, rresp, rlast, rid, exp_r[0].data, exp_r[0].resp, exp_r[0].last, exp_r[0].id);
                end
                if (rready) void'(exp_r.pop_front());
            end
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        checks++;
        if (exp_r.size() != 0) begin
            errors++; $display("FAIL r_timeout beats_left=%0d want 0", exp_r.size());
            exp_r.delete();
        end
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL r_done arready=%b rvalid=%b want 1 0", arready, rvalid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || {bid, bresp, rid, rdata, rresp} !== '0) begin
            errors++; $display("FAIL reset_outputs ready/valid=%b data=%h want all 0",
                               {awready, wready, bvalid, arready, rvalid, rlast}, rdata);
        end
        @(negedge aclk); areset_n = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset awready=%b arready=%b want 1 1", awready, arready);
        end
    endtask

    task automatic test_single();
        wd = '{32'hDEADBEEF}; ws = '{4'hF};
        do_write(32'h10, 8'd0, 2'b01, 3'd2, 4'h3, -1);
        do_read(32'h10, 8'd0, 2'b01, 4'h5, 1'b0);
    endtask

    task automatic test_incr();
        wd = '{32'd1, 32'd2, 32'd3, 32'd4}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h0, 8'd3, 2'b01, 3'd2, 4'h1, -1);
        do_read(32'h0, 8'd3, 2'b01, 4'h2, 1'b0);
        do_read(32'h0, 8'd3, 2'b01, 4'h7, 1'b1);
    endtask

    task automatic test_strobe_fixed();
        wd = '{32'hFFFFFFFF}; ws = '{4'hF};
        do_write(32'h20, 8'd0, 2'b01, 3'd2, 4'h4, -1);
        wd = '{32'h11111111, 32'h22222222}; ws = '{4'h1, 4'h4};
        do_write(32'h20, 8'd1, 2'b00, 3'd2, 4'h4, -1);
        do_read(32'h20, 8'd0, 2'b01, 4'h4, 1'b0);
    endtask

    task automatic test_errors();
        wd = '{32'hAAAAAAAA, 32'hBBBBBBBB}; ws = '{4'hF, 4'hF};
        do_write(32'h20, 8'd1, 2'b10, 3'd2, 4'h6, -1);
        do_write(32'h20, 8'd1, 2'b01, 3'd1, 4'h6, -1);
        do_read(32'h20, 8'd1, 2'b01, 4'h6, 1'b0);
        wd = '{32'h5A5A5A5A}; ws = '{4'hF};
        do_write(32'h3FC, 8'd0, 2'b01, 3'd2, 4'h8, -1);
        do_read(32'h3FC, 8'd1, 2'b01, 4'h8, 1'b0);
        do_read(32'h10, 8'd1, 2'b10, 4'h9, 1'b0);
        wd = '{32'hC0C0C0C0, 32'hC1C1C1C1}; ws = '{4'hF, 4'hF};
        do_write(32'h30, 8'd1, 2'b01, 3'd2, 4'hA, 0);
        do_write(32'h3FC, 8'd1, 2'b01, 3'd2, 4'hB, -1);
        do_read(32'h30, 8'd1, 2'b01, 4'hA, 1'b0);
    endtask

    task automatic test_concurrent();
        wd = '{32'h0BADF00D}; ws = '{4'hF};
        fork
            do_write(32'h10, 8'd0, 2'b01, 3'd2, 4'hC, -1);
            do_read(32'h10, 8'd0, 2'b01, 4'hD, 1'b0);
        join
        do_read(32'h10, 8'd0, 2'b01, 4'hD, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h40, 8'd3, 2'b01, 3'd2, 4'h1, -1);
        awid = 4'h2; awaddr = 32'h40; awlen = 8'd3; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 32'hB0 + 32'(b); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(posedge aclk); #1;
            model[16 + b] = 32'hB0 + 32'(b);
        end
        wdata = 32'hB2;
        #2 areset_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_burst ready/valid=%b want 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        wvalid = 1'b0;
        @(negedge aclk); areset_n = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_release awready=%b arready=%b bvalid=%b want 1 1 0", awready, arready, bvalid);
        end
        do_read(32'h40, 8'd3, 2'b01, 4'h3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [7:0] l;
        for (int i = 0; i < 4; i++) begin
            l = 8'($urandom_range(0, 7));
            a = 32'($urandom_range(64, 200)) << 2;
            wd.delete(); ws.delete();
            for (int b = 0; b <= int'(l); b++) begin
                wd.push_back($urandom);
                ws.push_back(4'hF);
            end
            do_write(a, l, 2'b01, 3'd2, 4'(i), -1);
            do_read(a, l, 2'b01, 4'(i), i[0]);
        end
    endtask

    initial begin
        {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
        {awid, arid, awaddr, araddr, awlen, arlen, awsize, arsize, awburst, arburst, wdata, wstrb} = '0;
        test_reset();
        test_single();
        test_incr();
        test_strobe_fixed();
        test_errors();
        test_concurrent();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
